// File: rtl/fetch_decode_pkg.sv
// Shared instruction-format constants for the YASAC control unit.
// Field positions, opcodes and register names are common to every unit that reads code words.
package fetch_decode_pkg;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 11;
  localparam int RA_MSB   = 10;
  localparam int RA_LSB   = 8;
  localparam int ZERO_MSB = 7;
  localparam int ZERO_LSB = 3;
  localparam int RB_MSB   = 2;
  localparam int RB_LSB   = 0;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  localparam logic [4:0] OP_MOV  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_LDI  = 5'd3;
  localparam logic [4:0] OP_STOP = 5'd31;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;
  localparam logic [2:0] R5 = 3'd5;
  localparam logic [2:0] R6 = 3'd6;
  localparam logic [2:0] R7 = 3'd7;

  // New immediate-format opcodes are added here so every decoder agrees on the format.
  function automatic logic is_imm_op(input logic [4:0] opcode);
    return opcode == OP_LDI;
  endfunction

endpackage

// File: rtl/fetch_decode_instr_field_decode.sv
// Pure combinational split of a 16-bit instruction word into its Format A / Format B fields.
module instr_field_decode
  import fetch_decode_pkg::*;
(
  input  logic [15:0] ir,
  output logic [4:0]  op,
  output logic [2:0]  ra,
  output logic [2:0]  rb,
  output logic [7:0]  imm,
  output logic        fmt_b,
  output logic        zero_ok
);

  assign op      = ir[OP_MSB:OP_LSB];
  assign ra      = ir[RA_MSB:RA_LSB];
  assign rb      = ir[RB_MSB:RB_LSB];
  assign imm     = ir[IMM_MSB:IMM_LSB];
  assign fmt_b   = is_imm_op(ir[OP_MSB:OP_LSB]);
  assign zero_ok = (ir[ZERO_MSB:ZERO_LSB] == 5'd0);

endmodule

// File: rtl/fetch_decode.sv
// YASAC control-unit front end: fetches code words, decodes them and issues them to the
// datapath over a valid/done handshake, handling jumps, STOP and illegal-word halts.
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter bit         CHECK_ZERO = 1'b1
)
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [7:0]  code_addr,
  input  logic [15:0] code_data,
  output logic [4:0]  op,
  output logic [2:0]  ra,
  output logic [2:0]  rb,
  output logic [7:0]  imm,
  output logic        fmt_b,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        pc_load,
  input  logic [7:0]  pc_load_val,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;
  logic        zero_ok;

  instr_field_decode u_field_decode (
    .ir      (ir_q),
    .op      (op),
    .ra      (ra),
    .rb      (rb),
    .imm     (imm),
    .fmt_b   (fmt_b),
    .zero_ok (zero_ok)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 16'h0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // PC is incremented at fetch, so a non-jumping EXEC leaves it pointing at the next word.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d   = ST_FETCH;
          pc_d      = RESET_PC;
          illegal_d = 1'b0;
        end
      end
      ST_FETCH: begin
        ir_d    = code_data;
        pc_d    = pc_q + 8'd1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (op == OP_STOP) begin
          state_d = ST_HALT;
        end else if (CHECK_ZERO && !fmt_b && !zero_ok) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          state_d = ST_FETCH;
          if (pc_load) begin
            pc_d = pc_load_val;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign code_addr   = pc_q;
  assign instr_valid = (state_q == ST_EXEC);
  assign busy        = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXEC);
  assign halted      = (state_q == ST_HALT);
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: directed program scenarios plus randomized programs
// checked against an instruction-level reference model of the fetch/decode/issue sequence.
module tb_fetch_decode;
  import fetch_decode_pkg::*;

  localparam logic [7:0] TB_RESET_PC = 8'h00;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  code_addr;
  logic [15:0] code_data;
  logic [4:0]  op;
  logic [2:0]  ra;
  logic [2:0]  rb;
  logic [7:0]  imm;
  logic        fmt_b;
  logic        instr_valid;
  logic        exec_done;
  logic        pc_load;
  logic [7:0]  pc_load_val;
  logic        busy;
  logic        halted;
  logic        illegal;

  logic [15:0] mem [256];
  assign code_data = mem[code_addr];

  fetch_decode #(.RESET_PC(TB_RESET_PC), .CHECK_ZERO(1'b1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .code_addr   (code_addr),
    .code_data   (code_data),
    .op          (op),
    .ra          (ra),
    .rb          (rb),
    .imm         (imm),
    .fmt_b       (fmt_b),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  int         compared   = 0;
  int         mismatched = 0;
  int         cycles     = 0;
  int         issueCount = 0;
  int         fixedDelay = -1;
  int         jumpPct    = 0;
  int         forceIssue = -1;
  logic [7:0] forceTarget = 8'h00;
  logic [7:0] mpc;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic d, input logic l, input logic [7:0] v);
    start       = s;
    exec_done   = d;
    pc_load     = l;
    pc_load_val = v;
    @(posedge clk);
    #1;
    cycles++;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_addr"},  32'(code_addr),   32'(TB_RESET_PC));
    checkOutput({tag, "_op"},    32'(op),          32'd0);
    checkOutput({tag, "_ra"},    32'(ra),          32'd0);
    checkOutput({tag, "_rb"},    32'(rb),          32'd0);
    checkOutput({tag, "_imm"},   32'(imm),         32'd0);
    checkOutput({tag, "_fmtb"},  32'(fmt_b),       32'd0);
    checkOutput({tag, "_valid"}, 32'(instr_valid), 32'd0);
    checkOutput({tag, "_busy"},  32'(busy),        32'd0);
    checkOutput({tag, "_halt"},  32'(halted),      32'd0);
    checkOutput({tag, "_ill"},   32'(illegal),     32'd0);
  endtask

  task automatic resetDut();
    reset_n     = 1'b0;
    start       = 1'b0;
    exec_done   = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = 8'h00;
    #1;
    checkAllZero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Model one instruction: entered just after the edge that put the DUT in FETCH.
  // status: 0 issued, 1 stopped, 2 halted on an illegal word.
  task automatic executeInstr(output int status);
    logic [15:0] w;
    logic [4:0]  eop;
    logic [4:0]  ezero;
    logic [2:0]  era;
    logic [2:0]  erb;
    logic [7:0]  eimm;
    logic        efb;
    logic        j;
    logic [7:0]  tgt;
    int          d;
    w     = mem[mpc];
    eop   = 5'(w >> 11);
    era   = 3'(w >> 8);
    erb   = 3'(w);
    eimm  = 8'(w);
    ezero = 5'(w >> 3);
    efb   = (eop == OP_LDI);
    checkOutput("fetch_addr",  32'(code_addr),   32'(mpc));
    checkOutput("fetch_busy",  32'(busy),        32'd1);
    checkOutput("fetch_valid", 32'(instr_valid), 32'd0);
    mpc = mpc + 8'd1;
    applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    checkOutput("decode_valid", 32'(instr_valid), 32'd0);
    checkOutput("decode_busy",  32'(busy),        32'd1);
    checkOutput("decode_op",    32'(op),          32'(eop));
    checkOutput("decode_ra",    32'(ra),          32'(era));
    applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    if (eop == OP_STOP) begin
      checkOutput("stop_halted", 32'(halted),      32'd1);
      checkOutput("stop_ill",    32'(illegal),     32'd0);
      checkOutput("stop_valid",  32'(instr_valid), 32'd0);
      checkOutput("stop_busy",   32'(busy),        32'd0);
      status = 1;
      return;
    end
    if (!efb && ezero != 5'd0) begin
      checkOutput("ill_halted", 32'(halted),      32'd1);
      checkOutput("ill_flag",   32'(illegal),     32'd1);
      checkOutput("ill_valid",  32'(instr_valid), 32'd0);
      status = 2;
      return;
    end
    d = (fixedDelay >= 0) ? fixedDelay : $urandom_range(0, 3);
    for (int k = 0; k <= d; k++) begin
      checkOutput("exec_valid", 32'(instr_valid), 32'd1);
      checkOutput("exec_op",    32'(op),          32'(eop));
      checkOutput("exec_ra",    32'(ra),          32'(era));
      checkOutput("exec_rb",    32'(rb),          32'(erb));
      checkOutput("exec_imm",   32'(imm),         32'(eimm));
      checkOutput("exec_fmtb",  32'(fmt_b),       32'(efb));
      checkOutput("exec_addr",  32'(code_addr),   32'(mpc));
      checkOutput("exec_halt",  32'(halted),      32'd0);
      if (k < d) begin
        applyStimulus(1'($urandom), 1'b0, 1'($urandom), 8'($urandom));
      end else begin
        j   = ($urandom_range(0, 99) < jumpPct);
        tgt = 8'($urandom);
        if (issueCount == forceIssue) begin
          j   = 1'b1;
          tgt = forceTarget;
        end
        applyStimulus(1'($urandom), 1'b1, j, tgt);
        if (j) mpc = tgt;
      end
    end
    issueCount++;
    status = 0;
  endtask

  task automatic runProgram(input int maxInstr, output int status, output int issues);
    mpc        = TB_RESET_PC;
    issueCount = 0;
    status     = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    cycles = 0;
    while (status == 0 && issueCount < maxInstr) executeInstr(status);
    issues = issueCount;
  endtask

  task automatic loadDemo();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = {OP_MOV, R1, 5'd0, R7};
    mem[1] = {OP_MOV, R0, 5'd0, R1};
    mem[2] = {OP_ADD, R0, 5'd0, R1};
    mem[3] = {OP_LDI, R2, 8'h05};
    mem[4] = {OP_SUB, R0, 5'd0, R2};
    mem[5] = {OP_MOV, R6, 5'd0, R0};
    mem[6] = {OP_STOP, 11'd0};
  endtask

  task automatic loadRandom();
    int         r;
    logic [4:0] sel;
    for (int i = 0; i < 256; i++) begin
      r   = $urandom_range(0, 99);
      sel = 5'($urandom_range(0, 3));
      if (r < 6)
        mem[i] = {OP_STOP, 11'($urandom)};
      else if (r < 12)
        mem[i] = {OP_ADD, 3'($urandom), 5'($urandom_range(1, 31)), 3'($urandom)};
      else if (sel == OP_LDI)
        mem[i] = {OP_LDI, 3'($urandom), 8'($urandom)};
      else
        mem[i] = {sel, 3'($urandom), 5'd0, 3'($urandom)};
    end
  endtask

  initial begin
    int status;
    int issues;
    reset_n = 1'b0;

    // Demo program, single-cycle EXEC: six issues, halt 20 cycles after start.
    loadDemo();
    resetDut();
    fixedDelay = 0;
    runProgram(20, status, issues);
    checkOutput("demo_status", 32'(status), 32'd1);
    checkOutput("demo_issues", 32'(issues), 32'd6);
    checkOutput("demo_cycles", 32'(cycles), 32'd20);

    // Slow datapath: every EXEC held 4 extra cycles.
    resetDut();
    fixedDelay = 4;
    runProgram(20, status, issues);
    checkOutput("slow_issues", 32'(issues), 32'd6);

    // Jump back to 0 after the third word: program loops.
    resetDut();
    fixedDelay  = 0;
    forceIssue  = 2;
    forceTarget = 8'h00;
    runProgram(8, status, issues);
    checkOutput("loop_issues", 32'(issues), 32'd8);
    forceIssue = -1;

    // Illegal MOV at address 0; start afterwards clears the flag.
    mem[0] = 16'b00000_001_00100_010;
    resetDut();
    runProgram(4, status, issues);
    checkOutput("illegal_status", 32'(status), 32'd2);
    checkOutput("illegal_issues", 32'(issues), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("restart_ill",  32'(illegal),   32'd0);
    checkOutput("restart_busy", 32'(busy),      32'd1);
    checkOutput("restart_addr", 32'(code_addr), 32'(TB_RESET_PC));

    // PC wrap: jump to 8'hFF, then the following fetch must be at 8'h00.
    loadDemo();
    mem[8'hFF] = {OP_ADD, R3, 5'd0, R4};
    resetDut();
    forceIssue  = 0;
    forceTarget = 8'hFF;
    runProgram(2, status, issues);
    checkOutput("wrap_addr", 32'(code_addr), 32'h00);
    forceIssue = -1;

    // Asynchronous reset while in EXEC.
    loadDemo();
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("pre_abort_valid", 32'(instr_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkAllZero("abort");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("post_abort_busy", 32'(busy),      32'd0);
    checkOutput("post_abort_halt", 32'(halted),    32'd0);
    checkOutput("post_abort_addr", 32'(code_addr), 32'(TB_RESET_PC));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("resume_busy", 32'(busy), 32'd1);

    // Randomized programs with random delays, jumps and input noise.
    fixedDelay = -1;
    jumpPct    = 20;
    for (int p = 0; p < 15; p++) begin
      loadRandom();
      resetDut();
      runProgram(30, status, issues);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
